// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side checker for the VGA output nets.
// Measures line/frame timing, tracks lock against the expected timing and
// counts lit pixels per frame. Drives no video.
module vga_timing_monitor #(
    parameter int unsigned H_TOTAL_CLK = 3200,
    parameter int unsigned H_SYNC_CLK  = 384,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned ERR_MAX     = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic        locked,
    output logic        no_signal,
    output logic        frame_done,
    output logic [15:0] h_period,
    output logic [15:0] h_width,
    output logic [11:0] v_lines,
    output logic [11:0] v_width,
    output logic [21:0] lit_count,
    output logic [7:0]  err_count
);

    localparam logic [15:0] H_TOT   = 16'(H_TOTAL_CLK);
    localparam logic [15:0] H_SYN   = 16'(H_SYNC_CLK);
    localparam logic [15:0] TIMEOUT = 16'(2 * H_TOTAL_CLK);
    localparam logic [11:0] V_TOT   = 12'(V_TOTAL);
    localparam logic [11:0] V_SYN   = 12'(V_SYNC);
    localparam logic [7:0]  E_MAX   = 8'(ERR_MAX);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic        err_inc, frame_done_nxt;

    logic        hs_s1, hs_s2, hs_d;
    logic        vs_s1, vs_s2, vs_d;
    logic [2:0]  rgb_s1, rgb_s2;
    logic        hs_fall, hs_rise, vs_fall, vs_rise;

    logic [15:0] hcnt, hw;
    logic        h_seen;
    logic        period_bad, width_bad, timeout;

    logic [11:0] lcnt, vwcnt;
    logic [21:0] lit;
    logic        line_bad, frame_ok;

    // Two-flop synchronisers plus one delay stage used for edge detection
    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_s1  <= 1'b1;
            hs_s2  <= 1'b1;
            hs_d   <= 1'b1;
            vs_s1  <= 1'b1;
            vs_s2  <= 1'b1;
            vs_d   <= 1'b1;
            rgb_s1 <= '0;
            rgb_s2 <= '0;
        end else begin
            hs_s1  <= hsync;
            hs_s2  <= hs_s1;
            hs_d   <= hs_s2;
            vs_s1  <= vsync;
            vs_s2  <= vs_s1;
            vs_d   <= vs_s2;
            rgb_s1 <= rgb;
            rgb_s2 <= rgb_s1;
        end
    end

    assign hs_fall = hs_d & ~hs_s2;
    assign hs_rise = ~hs_d & hs_s2;
    assign vs_fall = vs_d & ~vs_s2;
    assign vs_rise = ~vs_d & vs_s2;

    // A period latch is only meaningful once a previous hsync fall exists
    assign period_bad = hs_fall && h_seen && (hcnt != H_TOT);
    assign width_bad  = hs_rise && (hw != H_SYN);
    assign timeout    = (hcnt >= TIMEOUT) && !hs_fall;

    // Line timing: period between hsync falls, hsync low width, loss of signal
    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt      <= '0;
            hw        <= '0;
            h_seen    <= 1'b0;
            h_period  <= '0;
            h_width   <= '0;
            no_signal <= 1'b0;
        end else begin
            if (hs_fall) begin
                hcnt      <= 16'd1;
                h_seen    <= 1'b1;
                no_signal <= 1'b0;
                if (h_seen) begin
                    h_period <= hcnt;
                end
            end else begin
                if (hcnt != '1) begin
                    hcnt <= hcnt + 16'd1;
                end
                if (timeout) begin
                    no_signal <= 1'b1;
                end
            end

            if (hs_fall) begin
                hw <= 16'd1;
            end else if (!hs_s2 && (hw != '1)) begin
                hw <= hw + 16'd1;
            end

            if (hs_rise) begin
                h_width <= hw;
            end
        end
    end

    // A line event coincident with the vsync fall still belongs to the old frame
    assign frame_ok = !(line_bad || period_bad || width_bad) &&
                      (lcnt == V_TOT) && (v_width == V_SYN);

    // Frame measurements: line count, vsync width in lines, lit pixels, line errors
    always_ff @(posedge clk) begin
        if (!reset) begin
            lcnt      <= '0;
            vwcnt     <= '0;
            lit       <= '0;
            line_bad  <= 1'b0;
            v_lines   <= '0;
            v_width   <= '0;
            lit_count <= '0;
        end else begin
            if (vs_fall) begin
                v_lines <= lcnt;
                lcnt    <= hs_fall ? 12'd1 : 12'd0;
            end else if (hs_fall && (lcnt != '1)) begin
                lcnt <= lcnt + 12'd1;
            end

            if (vs_rise) begin
                v_width <= vwcnt;
                vwcnt   <= '0;
            end else if (hs_fall && !vs_s2 && (vwcnt != '1)) begin
                vwcnt <= vwcnt + 12'd1;
            end

            if (vs_fall) begin
                lit_count <= lit;
                lit       <= '0;
            end else if ((rgb_s2 != '0) && hs_s2 && vs_s2 && (lit != '1)) begin
                lit <= lit + 22'd1;
            end

            if (vs_fall) begin
                line_bad <= 1'b0;
            end else if (period_bad || width_bad) begin
                line_bad <= 1'b1;
            end
        end
    end

    // Lock state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Lock next-state: frame check at each vsync fall, timeout overrides all
    always_comb begin
        state_nxt      = state;
        err_inc        = 1'b0;
        frame_done_nxt = 1'b0;
        if (timeout) begin
            state_nxt = SEARCH;
        end else if (vs_fall) begin
            case (state)
                SEARCH: state_nxt = ACQUIRE;
                ACQUIRE, LOCKED: begin
                    frame_done_nxt = 1'b1;
                    if (frame_ok) begin
                        state_nxt = LOCKED;
                    end else begin
                        state_nxt = ACQUIRE;
                        err_inc   = 1'b1;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // Registered frame pulse and saturating error counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_done <= 1'b0;
            err_count  <= '0;
        end else begin
            frame_done <= frame_done_nxt;
            if (err_inc && (err_count != E_MAX)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Testbench for vga_timing_monitor: randomized video patterns, an event-level
// reference model and a scoreboard checked on every frame_done pulse.
module tb_vga_timing_monitor;

    localparam int H_TOT = 64;
    localparam int H_SYN = 8;
    localparam int V_TOT = 12;
    localparam int V_SYN = 2;
    localparam int E_MAX = 255;
    localparam int VOFF  = H_SYN + 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [2:0]  rgb = '0;
    logic        locked, no_signal, frame_done;
    logic [15:0] h_period, h_width;
    logic [11:0] v_lines, v_width;
    logic [21:0] lit_count;
    logic [7:0]  err_count;

    vga_timing_monitor #(
        .H_TOTAL_CLK(H_TOT),
        .H_SYNC_CLK (H_SYN),
        .V_TOTAL    (V_TOT),
        .V_SYNC     (V_SYN),
        .ERR_MAX    (E_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hsync     (hsync),
        .vsync     (vsync),
        .rgb       (rgb),
        .locked    (locked),
        .no_signal (no_signal),
        .frame_done(frame_done),
        .h_period  (h_period),
        .h_width   (h_width),
        .v_lines   (v_lines),
        .v_width   (v_width),
        .lit_count (lit_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v_lines;
        int v_width;
        int lit;
        int h_period;
        int h_width;
        int locked;
        int err;
    } exp_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: works on pin-level edge timestamps and frame tallies
    typedef enum {M_SEARCH, M_ACQUIRE, M_LOCKED} mstate_t;
    mstate_t m_state;
    int  cyc = 0;
    bit  p_h, p_v;
    int  last_fall;
    bit  have_fall;
    int  m_period, m_width, m_vwidth, m_err;
    int  frame_lines, low_falls, lit_acc;
    bit  frame_bad, m_nosig;

    task automatic model_reset();
        m_state = M_SEARCH;
        p_h = 1'b1; p_v = 1'b1;
        last_fall = cyc; have_fall = 1'b0;
        m_period = 0; m_width = 0; m_vwidth = 0; m_err = 0;
        frame_lines = 0; low_falls = 0; lit_acc = 0;
        frame_bad = 1'b0; m_nosig = 1'b0;
    endtask

    task automatic model_cycle(input bit h, input bit v, input logic [2:0] c);
        bit hf, hr, vf, vr, bad_now, ok;
        exp_t e;
        cyc++;
        hf = p_h && !h; hr = !p_h && h;
        vf = p_v && !v; vr = !p_v && v;
        bad_now = 1'b0;
        if (hr) begin
            m_width = cyc - last_fall;
            if (m_width != H_SYN) bad_now = 1'b1;
        end
        if (hf) begin
            if (have_fall) begin
                m_period = (cyc - last_fall > 65535) ? 65535 : cyc - last_fall;
                if (m_period != H_TOT) bad_now = 1'b1;
            end
            have_fall = 1'b1;
            last_fall = cyc;
            m_nosig = 1'b0;
        end else if (cyc - last_fall >= 2 * H_TOT) begin
            m_nosig = 1'b1;
            m_state = M_SEARCH;
        end
        if (vr) begin
            m_vwidth = low_falls;
            low_falls = 0;
        end
        if (vf) begin
            ok = !(frame_bad || bad_now) && frame_lines == V_TOT && m_vwidth == V_SYN;
            if (m_state == M_SEARCH) begin
                m_state = M_ACQUIRE;
            end else begin
                if (ok) m_state = M_LOCKED;
                else begin
                    m_state = M_ACQUIRE;
                    if (m_err < E_MAX) m_err++;
                end
                e.v_lines = frame_lines; e.v_width = m_vwidth; e.lit = lit_acc;
                e.h_period = m_period; e.h_width = m_width;
                e.locked = (m_state == M_LOCKED) ? 1 : 0; e.err = m_err;
                sbq.push_back(e);
            end
            frame_lines = 0; lit_acc = 0; frame_bad = 1'b0;
        end else if (bad_now) begin
            frame_bad = 1'b1;
        end
        if (hf) begin
            frame_lines++;
            if (!v) low_falls++;
        end
        if (c != 3'b000 && h && v) lit_acc++;
        p_h = h; p_v = v;
    endtask

    task automatic drive(input bit h, input bit v, input logic [2:0] c);
        @(posedge clk); #1;
        hsync = h; vsync = v; rgb = c;
        model_cycle(h, v, c);
    endtask

    // One frame: vsync low for V_SYN lines, either aligned with the line's
    // hsync fall (coinc) or offset VOFF clocks into the line.
    // lit_n < 0 gives random rgb everywhere; otherwise exactly lit_n lit clocks.
    task automatic gen_frame(input int nlines, input int len, input int bad_line,
                             input int bad_len, input bit coinc, input int lit_n);
        int remaining = lit_n;
        for (int i = 0; i < nlines; i++) begin
            int L = (i == bad_line) ? bad_len : len;
            for (int j = 0; j < L; j++) begin
                bit h, v;
                logic [2:0] c;
                h = (j >= H_SYN);
                if (coinc) v = !(i < V_SYN);
                else v = !((i == 0 && j >= VOFF) || (i > 0 && i < V_SYN) || (i == V_SYN && j < VOFF));
                if (lit_n < 0) c = 3'($urandom_range(0, 7));
                else if (h && v && remaining > 0 && j >= H_SYN + 4 && j < L - 4) begin
                    c = 3'b111;
                    remaining--;
                end else c = 3'b000;
                drive(h, v, c);
            end
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        check(name, sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_no_signal"}, no_signal, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_h_period"}, h_period, 0);
        check({tag, "_h_width"}, h_width, 0);
        check({tag, "_v_lines"}, v_lines, 0);
        check({tag, "_v_width"}, v_width, 0);
        check({tag, "_lit_count"}, lit_count, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    // Monitor: every frame_done pulse must match the oldest expected frame
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && frame_done) begin
                if (sbq.size() == 0) begin
                    check("frame_done_unexpected", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("v_lines", v_lines, e.v_lines);
                    check("v_width", v_width, e.v_width);
                    check("lit_count", lit_count, e.lit);
                    check("h_period", h_period, e.h_period);
                    check("h_width", h_width, e.h_width);
                    check("locked", locked, e.locked);
                    check("err_count", err_count, e.err);
                    check("no_signal", no_signal, 0);
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        model_reset();

        // Nominal timing: lock after the second vsync fall
        repeat (4) gen_frame(V_TOT, H_TOT, -1, 0, 1'b0, -1);

        // One long line in a locked frame, then recovery
        gen_frame(V_TOT, H_TOT, 5, H_TOT + 4, 1'b0, -1);
        repeat (2) gen_frame(V_TOT, H_TOT, -1, 0, 1'b0, -1);

        // Loss of hsync long past the timeout
        repeat (2 * H_TOT + 60) drive(1'b1, 1'b1, 3'b000);
        check("timeout_no_signal", no_signal, m_nosig);
        check("timeout_locked", locked, 0);
        for (int j = 0; j < H_TOT; j++) begin
            drive(j >= H_SYN, 1'b1, 3'b000);
            if (j == 5) check("resume_no_signal", no_signal, m_nosig);
        end

        // Coincident hsync/vsync falls, then exact lit-pixel frame
        repeat (3) gen_frame(V_TOT, H_TOT, -1, 0, 1'b1, -1);
        gen_frame(V_TOT, H_TOT, -1, 0, 1'b1, 300);
        gen_frame(V_TOT, H_TOT, -1, 0, 1'b1, -1);

        // Many short bad frames: error counter saturates
        repeat (300) gen_frame(3, 20, -1, 0, 1'b0, -1);
        repeat (2) gen_frame(V_TOT, H_TOT, -1, 0, 1'b0, -1);
        check("err_saturated", err_count, m_err);

        // Reset in the middle of a frame
        gen_frame(5, H_TOT, -1, 0, 1'b0, -1);
        repeat (30) drive(1'b1, 1'b1, 3'($urandom_range(0, 7)));
        drain("drain_before_reset");
        @(posedge clk); #1;
        reset = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0;
        @(posedge clk); #1;
        check_all_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (3) gen_frame(V_TOT, H_TOT, -1, 0, 1'b0, -1);
        drain("drain_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
